// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state encodings, parity-mode constants and default bit divider for the UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam int DEF_CLK_DIV = 434;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; ports clk rst, push/din in, pop/dout out, full empty count status
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign count = cnt_q;
  assign dout = mem_q[rd_q];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = din;
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: queued RS232 transmitter; ports clk rst, tx_data/tx_valid/tx_ready push, parity_mode (only with UART_TX_PARITY_EN), busy fifo_count txd
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int CLK_DIV    = DEF_CLK_DIV,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                    parity_mode,
`endif
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          txd
);
  localparam int CW = $clog2(CLK_DIV);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] bidx_q, bidx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, head;
  logic txd_q, txd_d, full, empty, pop, bit_end;
`ifdef UART_TX_PARITY_EN
  logic par_q, par_d, par_on_q, par_on_d;
`endif
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(tx_valid && tx_ready),
    .pop(pop),
    .din(tx_data),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(fifo_count)
  );
  assign tx_ready = !full && !rst;
  assign busy = state_q != S_IDLE || !empty;
  assign txd = txd_q;
  assign bit_end = cnt_q == CW'(CLK_DIV-1);
  always_comb begin
    state_d = state_q;
    bidx_d = bidx_q;
    sh_d = sh_q;
    pop = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d = par_q;
    par_on_d = par_on_q;
`endif
    case (state_q)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        state_d = S_START;
      end
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: if (bit_end) begin
        sh_d = sh_q >> 1;
        bidx_d = bidx_q + 1'b1;
`ifdef UART_TX_PARITY_EN
        if (bidx_q == 4'(DATA_BITS-1)) state_d = par_on_q ? S_PARITY : S_STOP;
`else
        if (bidx_q == 4'(DATA_BITS-1)) state_d = S_STOP;
`endif
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) state_d = S_STOP;
`endif
      S_STOP: if (bit_end) begin
        bidx_d = bidx_q + 1'b1;
        if (bidx_q == 4'(STOP_BITS-1)) begin
          pop = !empty;
          state_d = empty ? S_IDLE : S_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      sh_d = head;
`ifdef UART_TX_PARITY_EN
      par_d = (^head) ^ (parity_mode == PAR_ODD);
      par_on_d = parity_mode == PAR_EVEN || parity_mode == PAR_ODD;
`endif
    end
    // the per-bit counter restarts both at each bit boundary and on entry to a new state
    cnt_d = (bit_end || state_d != state_q) ? '0 : cnt_q + 1'b1;
    if (state_d != state_q) bidx_d = '0;
    // txd is computed from next-state values so the registered line changes with the state
    txd_d = 1'b1;
    if (state_d == S_START) txd_d = 1'b0;
    if (state_d == S_DATA) txd_d = sh_d[0];
`ifdef UART_TX_PARITY_EN
    if (state_d == S_PARITY) txd_d = par_d;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      bidx_q <= '0;
      sh_q <= '0;
      txd_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bidx_q <= bidx_d;
      sh_q <= sh_d;
      txd_q <= txd_d;
    end
  end
`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
      par_on_q <= 1'b0;
    end else begin
      par_q <= par_d;
      par_on_q <= par_on_d;
    end
  end
`endif
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: self-checking bench comparing the transmitter against a frame-level line model
module tb_uart_tx_fifo;
  localparam int DB = 8, SB = 1, CD = 4, FD = 4;
  logic clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, tx_ready, busy, txd;
  logic [DB-1:0] tx_data = '0;
  logic [$clog2(FD):0] fifo_count;
  logic v1 = 1'b0, rdy1, busy1, txd1;
  logic [6:0] d1 = '0;
  logic [1:0] cnt1;
`ifdef UART_TX_PARITY_EN
  logic [1:0] parity_mode = 2'b00;
  logic [1:0] pm1 = 2'b00;
`endif
  int total = 0, bad = 0;
  logic [DB-1:0] q[$];
  bit fb[$];
  bit e1[$];
  int flen = 0, rem = 0;
  logic acc;
  always #5 clk = ~clk;
  uart_tx_fifo #(.DATA_BITS(DB), .STOP_BITS(SB), .CLK_DIV(CD), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
`ifdef UART_TX_PARITY_EN
    .parity_mode(parity_mode),
`endif
    .busy(busy), .fifo_count(fifo_count), .txd(txd)
  );
  uart_tx_fifo #(.DATA_BITS(7), .STOP_BITS(2), .CLK_DIV(3), .FIFO_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
`ifdef UART_TX_PARITY_EN
    .parity_mode(pm1),
`endif
    .busy(busy1), .fifo_count(cnt1), .txd(txd1)
  );
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic void load(input logic [DB-1:0] d, input logic [1:0] pm);
    fb.delete();
    fb.push_back(1'b0);
    for (int i = 0; i < DB; i++) fb.push_back(d[i]);
    if (pm == 2'b01 || pm == 2'b10) fb.push_back((^d) ^ (pm == 2'b10));
    for (int i = 0; i < SB; i++) fb.push_back(1'b1);
    flen = fb.size() * CD;
  endfunction
  task automatic tick();
    logic pv, pr;
    logic [DB-1:0] pd;
    logic [1:0] pm;
    int qs;
    pv = tx_valid;
    pd = tx_data;
    pr = rst;
    qs = q.size();
    pm = 2'b00;
`ifdef UART_TX_PARITY_EN
    pm = parity_mode;
`endif
    @(posedge clk);
    if (pr) begin
      q.delete();
      rem = 0;
    end else begin
      if (rem > 0) rem--;
      if (rem == 0 && qs > 0) begin
        load(q.pop_front(), pm);
        rem = flen;
      end
      if (pv && qs < FD) q.push_back(pd);
    end
    #1;
    chk("txd", {7'b0, txd}, {7'b0, rem > 0 ? fb[(flen - rem) / CD] : 1'b1});
    chk("busy", {7'b0, busy}, {7'b0, rem > 0 || q.size() > 0});
    chk("fifo_count", 8'(fifo_count), 8'(q.size()));
    chk("tx_ready", {7'b0, tx_ready}, {7'b0, !rst && q.size() < FD});
  endtask
  task automatic drain();
    for (int i = 0; i < 3000 && (rem > 0 || q.size() > 0); i++) tick();
    tick();
  endtask
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    tick();
    tx_data = 8'h55;
    tx_valid = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tx_data = DB'($urandom);
      tick();
    end
    chk("full_after_burst", {7'b0, tx_ready}, 8'h00);
    tx_data = DB'($urandom);
    acc = 1'b0;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = tx_ready;
      tick();
    end
    tx_valid = 1'b0;
    chk("fifth_accepted", {7'b0, acc}, 8'h01);
    drain();
    for (int i = 0; i < 40; i++) begin
      tx_valid = ($urandom % 3) == 0;
      tx_data = DB'($urandom);
`ifdef UART_TX_PARITY_EN
      parity_mode = 2'($urandom);
`endif
      tick();
    end
    tx_valid = 1'b0;
    drain();
`ifdef UART_TX_PARITY_EN
    for (int m = 1; m < 4; m++) begin
      parity_mode = 2'(m);
      tx_data = 8'hA3;
      tx_valid = 1'b1;
      tick();
      tx_valid = 1'b0;
      repeat (3) tick();
      parity_mode = 2'($urandom);
      drain();
    end
    parity_mode = 2'b00;
`endif
    tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_data = DB'($urandom);
      tick();
    end
    tx_valid = 1'b0;
    for (int i = 0; i < 200 && !(rem > 0 && (flen - rem) / CD == 4); i++) tick();
    chk("reached_bit3", {7'b0, rem > 0 && (flen - rem) / CD == 4}, 8'h01);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (60) tick();
    e1.delete();
    d1 = 7'h7F;
    v1 = 1'b1;
    tick();
    for (int f = 0; f < 2; f++) begin
      e1.push_back(1'b0);
      for (int i = 0; i < 7; i++) e1.push_back(d1[i]);
      e1.push_back(1'b1);
      e1.push_back(1'b1);
      if (f == 0) d1 = 7'($urandom);
    end
    tick();
    v1 = 1'b0;
    chk("s2_count", {6'b0, cnt1}, 8'h01);
    chk("s2_ready", {7'b0, rdy1}, 8'h01);
    chk("s2_txd0", {7'b0, txd1}, {7'b0, e1[0]});
    for (int k = 1; k < 60; k++) begin
      tick();
      chk("s2_txd", {7'b0, txd1}, {7'b0, e1[k / 3]});
      chk("s2_busy", {7'b0, busy1}, 8'h01);
    end
    tick();
    chk("s2_idle_busy", {7'b0, busy1}, 8'h00);
    chk("s2_idle_txd", {7'b0, txd1}, 8'h01);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
